// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path (package rf_pkg).
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating pointer plus a priority search starting at that pointer.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ptr;

    always_comb begin
        int idx;
        logic [IW-1:0] idx_l;
        idx       = 0;
        idx_l     = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(ptr) + k) % N;
            idx_l = IW'(idx);
            if (!any && req[idx_l]) begin
                any          = 1'b1;
                grant[idx_l] = 1'b1;
                grant_idx    = idx_l;
            end
        end
    end

    // Pointer moves one past the winner so that requester gets lowest priority next.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the single register-file write port through a one-entry stage.
// Optional macro RF_WB_BYPASS_EN exposes the pending stage entry for same-cycle forwarding.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    input  logic                           rf_hold,
    output logic                           rf_w_en,
    output logic [ADDR_W-1:0]              rf_w_addr,
    output logic [DATA_W-1:0]              rf_w_data,
    output logic [IDW-1:0]                 grant_id
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                           byp_valid,
    output logic [ADDR_W-1:0]              byp_addr,
    output logic [DATA_W-1:0]              byp_data
`endif
);

    rf_wr_t               req_wr [NUM_REQ];
    rf_wr_t               win_wr;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 any_valid;
    logic                 accept;

    rf_wr_t               stage_p1;
    logic                 vld_p1;
    logic [IDW-1:0]       grant_id_p1;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_wr[i].addr = RF_ADDR_W'(req_addr[i]);
            req_wr[i].data = RF_DATA_W'(req_data[i]);
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_valid)
    );

    assign accept    = any_valid & ~rf_hold;
    assign req_ready = grant & {NUM_REQ{accept}};
    assign win_wr    = req_wr[grant_idx];

    // ---- stage p1: one-entry output stage, drains every cycle unless held ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            stage_p1    <= '0;
            grant_id_p1 <= '0;
        end else if (!rf_hold) begin
            vld_p1 <= accept;
            if (accept) begin
                stage_p1    <= win_wr;
                grant_id_p1 <= grant_idx;
            end
        end
    end

    // A reset in progress also blocks the commit of any entry still sitting in the stage.
    assign rf_w_en   = vld_p1 & ~rf_hold & ~rst & (stage_p1.addr != RF_ZERO_ADDR);
    assign rf_w_addr = ADDR_W'(stage_p1.addr);
    assign rf_w_data = DATA_W'(stage_p1.data);
    assign grant_id  = grant_id_p1;

`ifdef RF_WB_BYPASS_EN
    assign byp_valid = vld_p1 & (stage_p1.addr != RF_ZERO_ADDR);
    assign byp_addr  = ADDR_W'(stage_p1.addr);
    assign byp_data  = DATA_W'(stage_p1.data);
`endif

endmodule
